// File: rtl/queen_pkg.sv
// Shared types and constants for the N-queens backtracking solver.
package queen_pkg;

  localparam int MAX_N   = 8;
  localparam int COORD_W = 3;
  localparam int BOARD_W = COORD_W * MAX_N;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    BACKTRACK,
    EMIT,
    FINISH
  } state_e;

endpackage

// File: rtl/is_safe.sv
// Pairwise queen comparator: two queens in distinct columns are safe when they
// share neither a row nor a diagonal.
module is_safe
  import queen_pkg::*;
(
  input  coord_t row_a,
  input  coord_t col_a,
  input  coord_t row_b,
  input  coord_t col_b,
  output logic   safe
);

  coord_t d_row;
  coord_t d_col;

  always_comb begin
    d_row = (row_a > row_b) ? (row_a - row_b) : (row_b - row_a);
    d_col = (col_a > col_b) ? (col_a - col_b) : (col_b - col_a);
    safe  = (d_row != '0) && (d_row != d_col);
  end

endmodule

// File: rtl/queen_row_stack.sv
// Row stack: one queen row per column, one write port, two read ports, plus the
// packed board view. Entries at columns >= N are never written and stay 0.
module queen_row_stack
  import queen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  coord_t             waddr,
  input  coord_t             wdata,
  input  coord_t             raddr_a,
  output coord_t             rdata_a,
  input  coord_t             raddr_b,
  output coord_t             rdata_b,
  output logic [BOARD_W-1:0] board
);

  coord_t rows_q [MAX_N];
  coord_t rows_d [MAX_N];

  always_comb begin
    for (int i = 0; i < MAX_N; i++) begin
      rows_d[i] = rows_q[i];
      if (we && (waddr == COORD_W'(i)) && (i < N)) rows_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_N; i++) rows_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_N; i++) rows_q[i] <= rows_d[i];
    end
  end

  always_comb begin
    rdata_a = rows_q[raddr_a];
    rdata_b = rows_q[raddr_b];
    board   = '0;
    for (int i = 0; i < MAX_N; i++) board[i*COORD_W +: COORD_W] = rows_q[i];
  end

endmodule

// File: rtl/queen_solver_ctrl.sv
// Backtracking N-queens controller: column-by-column placement, one pairwise
// safety check per cycle, solutions handed out over a valid/ready handshake.
module queen_solver_ctrl
  import queen_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               find_all,
  output logic               busy,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [BOARD_W-1:0] sol_rows,
  output logic [CNT_W-1:0]   sol_count,
  output logic               done
);

  localparam coord_t LAST = COORD_W'(N - 1);

  state_e             state_q, state_d;
  coord_t             c_q, c_d;
  coord_t             r_q, r_d;
  logic [3:0]         k_q, k_d;
  logic               find_all_q, find_all_d;
  logic [CNT_W-1:0]   sol_count_q, sol_count_d;

  logic               st_we;
  coord_t             rows_k;
  coord_t             rows_cm1;
  logic [BOARD_W-1:0] board;
  logic               safe;

  queen_row_stack #(.N(N)) u_row_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (st_we),
    .waddr   (c_q),
    .wdata   (r_q),
    .raddr_a (k_q[COORD_W-1:0]),
    .rdata_a (rows_k),
    .raddr_b (c_q - 1'b1),
    .rdata_b (rows_cm1),
    .board   (board)
  );

  is_safe u_is_safe (
    .row_a (rows_k),
    .col_a (k_q[COORD_W-1:0]),
    .row_b (r_q),
    .col_b (c_q),
    .safe  (safe)
  );

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    r_d         = r_q;
    k_d         = k_q;
    find_all_d  = find_all_q;
    sol_count_d = sol_count_q;
    st_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          c_d         = '0;
          r_d         = '0;
          k_d         = '0;
          sol_count_d = '0;
          find_all_d  = find_all;
          state_d     = CHECK;
        end
      end

      CHECK: begin
        if (k_q == {1'b0, c_q}) begin
          st_we = 1'b1;
          if (c_q == LAST) begin
            state_d = EMIT;
          end else begin
            c_d = c_q + 1'b1;
            r_d = '0;
            k_d = '0;
          end
        end else if (safe) begin
          k_d = k_q + 4'd1;
        end else if (r_q == LAST) begin
          state_d = BACKTRACK;
        end else begin
          r_d = r_q + 1'b1;
          k_d = '0;
        end
      end

      BACKTRACK: begin
        if (c_q == '0) begin
          state_d = FINISH;
        end else begin
          c_d = c_q - 1'b1;
          if (rows_cm1 != LAST) begin
            r_d     = rows_cm1 + 1'b1;
            k_d     = '0;
            state_d = CHECK;
          end
        end
      end

      // k still equals c (= N-1) here, so rows_k is the last column's row.
      EMIT: begin
        if (sol_ready) begin
          if (sol_count_q != '1) sol_count_d = sol_count_q + CNT_W'(1);
          if (!find_all_q) begin
            state_d = FINISH;
          end else if (rows_k == LAST) begin
            state_d = BACKTRACK;
          end else begin
            r_d     = rows_k + 1'b1;
            k_d     = '0;
            state_d = CHECK;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      find_all_q  <= 1'b0;
      sol_count_q <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      k_q         <= k_d;
      find_all_q  <= find_all_d;
      sol_count_q <= sol_count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign sol_valid = (state_q == EMIT);
  assign done      = (state_q == FINISH);
  assign sol_rows  = sol_valid ? board : '0;
  assign sol_count = sol_count_q;

endmodule

// File: tb/tb_queen_solver_ctrl.sv
// Bench for queen_solver_ctrl: five instances (N = 1,2,3,4,8) checked against a
// permutation-enumerating N-queens model, plus table vectors and corner sequences.
module tb_queen_solver_ctrl;
  localparam int NI     = 5;
  localparam int BUDGET = 120000;

  logic        clk;
  logic        rst_n;
  logic        start_a     [NI];
  logic        find_all_a  [NI];
  logic        sol_ready_a [NI];
  logic        busy_a      [NI];
  logic        sol_valid_a [NI];
  logic        done_a      [NI];
  logic [23:0] sol_rows_a  [NI];
  logic [6:0]  sol_count_a [NI];

  int vectors;
  int miscompares;

  logic [23:0] exp_q[$];
  logic [23:0] cap_q[$];

  function automatic int nval(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 8;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 8;
    queen_solver_ctrl #(.N(NG), .CNT_W(7)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a[g]),
      .find_all  (find_all_a[g]),
      .busy      (busy_a[g]),
      .sol_valid (sol_valid_a[g]),
      .sol_ready (sol_ready_a[g]),
      .sol_rows  (sol_rows_a[g]),
      .sol_count (sol_count_a[g]),
      .done      (done_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack(input int r [8], input int n);
    logic [23:0] b = '0;
    for (int c = 0; c < n; c++) b[3*c +: 3] = 3'(r[c]);
    return b;
  endfunction

  // All solutions in lexicographic order (column 0 most significant), obtained by
  // walking every row permutation and keeping those with no shared diagonal.
  task automatic fill_model(input int n);
    int a [8];
    int i, j, t;
    bit ok;
    exp_q.delete();
    for (int x = 0; x < 8; x++) a[x] = x;
    while (1) begin
      ok = 1;
      for (int p = 0; p < n; p++)
        for (int q = p + 1; q < n; q++)
          if ((a[p] - a[q] == q - p) || (a[q] - a[p] == q - p)) ok = 0;
      if (ok) exp_q.push_back(pack(a, n));
      i = n - 2;
      while (i >= 0 && a[i] > a[i+1]) i--;
      if (i < 0) break;
      j = n - 1;
      while (a[j] < a[i]) j--;
      t = a[i]; a[i] = a[j]; a[j] = t;
      for (int lo = i + 1, hi = n - 1; lo < hi; lo++, hi--) begin
        t = a[lo]; a[lo] = a[hi]; a[hi] = t;
      end
    end
  endtask

  task automatic run_search(input int i, input bit fa, input int stall, input bit rnd,
                            input bit repulse, input int exp_count);
    int n = nval(i);
    int got = 0, cyc = 0, stall_left = 0;
    bit in_valid = 0, repulsed = 0, finished = 0;
    logic [23:0] held = '0;
    fill_model(n);
    if (!fa) while (exp_q.size() > 1) void'(exp_q.pop_back());
    cap_q.delete();
    @(negedge clk);
    start_a[i] = 1'b1; find_all_a[i] = fa; sol_ready_a[i] = 1'b0;
    @(negedge clk);
    start_a[i] = 1'b0; find_all_a[i] = 1'($urandom);
    chk("busy_after_start", busy_a[i], 1);
    while (!finished && cyc < BUDGET) begin
      start_a[i] = 1'b0;
      if (sol_valid_a[i]) begin
        if (!in_valid) begin
          in_valid = 1; held = sol_rows_a[i];
          stall_left = rnd ? int'($urandom_range(0, 4)) : stall;
          chk("sol_count_at_valid", sol_count_a[i], got);
          if (got < exp_q.size()) chk("sol_rows", sol_rows_a[i], exp_q[got]);
          else chk("extra_solution_index", got, exp_q.size());
        end else begin
          chk("rows_stable", sol_rows_a[i], held);
        end
        if (stall_left == 0) begin
          sol_ready_a[i] = 1'b1; cap_q.push_back(held); got++; in_valid = 0;
        end else begin
          sol_ready_a[i] = 1'b0; stall_left--;
        end
      end else begin
        sol_ready_a[i] = 1'($urandom);
        if (repulse && !repulsed && got >= 1 && busy_a[i] && !done_a[i]) begin
          start_a[i] = 1'b1; repulsed = 1;
        end
      end
      if (done_a[i]) begin
        finished = 1;
        chk("count_at_done_model", sol_count_a[i], exp_q.size());
        chk("count_at_done_table", sol_count_a[i], exp_count);
        chk("handshakes", got, exp_q.size());
      end
      @(negedge clk); cyc++;
    end
    start_a[i] = 1'b0;
    sol_ready_a[i] = 1'b0;
    if (!finished) chk("timeout_done_seen", 0, 1);
    else begin
      chk("done_one_cycle", done_a[i], 0);
      chk("busy_after_done", busy_a[i], 0);
      chk("count_held", sol_count_a[i], exp_count);
    end
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_busy", busy_a[i], 0);
    chk("rst_valid", sol_valid_a[i], 0);
    chk("rst_done", done_a[i], 0);
    chk("rst_count", sol_count_a[i], 0);
    chk("rst_rows", sol_rows_a[i], 0);
  endtask

  typedef struct {
    int idx;
    bit fa;
    int stall;
    bit rnd;
    bit repulse;
    int exp_count;
  } vec_t;

  vec_t vt[$];
  int g8 [8];
  int g4a [8];
  int g4b [8];

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 0; find_all_a[i] = 0; sol_ready_a[i] = 0;
    end
    g8  = '{0, 4, 7, 5, 2, 6, 1, 3};
    g4a = '{1, 3, 0, 2, 0, 0, 0, 0};
    g4b = '{2, 0, 3, 1, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) chk_reset_vals(i);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk_reset_vals(i);

    vt.push_back('{4, 0, 0,  0, 0, 1});
    vt.push_back('{4, 1, 0,  0, 1, 92});
    vt.push_back('{3, 1, 10, 0, 0, 2});
    vt.push_back('{1, 1, 0,  0, 0, 0});
    vt.push_back('{2, 1, 0,  0, 0, 0});
    vt.push_back('{0, 1, 0,  0, 0, 1});
    vt.push_back('{0, 0, 3,  0, 0, 1});
    vt.push_back('{3, 1, 0,  1, 1, 2});
    vt.push_back('{3, 0, 0,  1, 0, 1});
    vt.push_back('{2, 0, 2,  0, 0, 0});
    foreach (vt[v])
      run_search(vt[v].idx, vt[v].fa, vt[v].stall, vt[v].rnd, vt[v].repulse, vt[v].exp_count);

    // Randomized runs over the small boards.
    for (int t = 0; t < 6; t++) begin
      int i = int'($urandom_range(0, 3));
      bit fa = 1'($urandom);
      fill_model(nval(i));
      run_search(i, fa, 0, 1, 1'($urandom), fa ? exp_q.size() : (exp_q.size() > 0 ? 1 : 0));
    end

    // N=8 first solution, explicit rows.
    run_search(4, 0, 0, 0, 0, 1);
    chk("n8_first_count", cap_q.size(), 1);
    if (cap_q.size() > 0) chk("n8_first_rows", cap_q[0], pack(g8, 8));

    // N=4 with 10-cycle stalls, explicit rows.
    run_search(3, 1, 10, 0, 0, 2);
    chk("n4_count", cap_q.size(), 2);
    if (cap_q.size() > 1) begin
      chk("n4_sol0", cap_q[0], pack(g4a, 4));
      chk("n4_sol1", cap_q[1], pack(g4b, 4));
    end

    // Reset mid-search, then rerun.
    @(negedge clk);
    start_a[4] = 1'b1; find_all_a[4] = 1'b0;
    @(negedge clk);
    start_a[4] = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_search_busy", busy_a[4], 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(4);
    @(negedge clk);
    chk_reset_vals(4);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals(4);
    run_search(4, 0, 0, 0, 0, 1);
    if (cap_q.size() > 0) chk("rerun_rows", cap_q[0], pack(g8, 8));
    else chk("rerun_count", cap_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
